airlock_cycle_controller: RTL
=============================

AIRLOCK_CYCLE_CONTROLLER -- requirements
Module: airlock_cycle_controller

Interface
REQ-001 SHALL have parameter PUMP_TIMEOUT, default 8: max clocks allowed in one equalize phase before fault.
REQ-002 SHALL have parameter TIMER_WIDTH, default 4: pump timer width; PUMP_TIMEOUT SHALL fit in TIMER_WIDTH bits.
REQ-003 SHALL have port clock, input, 1: single clock; all state changes on rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high.
REQ-005 SHALL have port start, input, 1: request a cycle; sampled only in IDLE.
REQ-006 SHALL have port mode, input, 1: 0 = arrival (outer to inner), 1 = departure (inner to outer); sampled with start.
REQ-007 SHALL have port abort, input, 1: cancel request.
REQ-008 SHALL have port odClosed, input, 1: outer door closed.
REQ-009 SHALL have port idClosed, input, 1: inner door closed.
REQ-010 SHALL have port isHighPressure, input, 1: chamber at station pressure.
REQ-011 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-012 SHALL have ports startPressurizing and startDepressurizing, outputs, 1 each: pump commands.
REQ-013 SHALL have ports odUnlock and idUnlock, outputs, 1 each: door unlock commands.
REQ-014 SHALL have ports done and fault, outputs, 1 each: cycle-complete pulse; sticky error.

Function
REQ-015 SHALL be a Moore FSM; every output SHALL be decoded from registered state only.
REQ-016 SHALL implement states IDLE, SEAL, EQ1, OPEN1, ENTER, EQ2, OPEN2, EXIT, DONE, FAULT.
REQ-017 IDLE: start=1 SHALL latch mode and move to SEAL next edge; busy SHALL rise one cycle after start is sampled.
REQ-018 SEAL: SHALL wait until odClosed=1 and idClosed=1, then go to EQ1.
REQ-019 Entry side SHALL be outer (target low pressure) for arrival and inner (target high pressure) for departure; exit side SHALL be the opposite.
REQ-020 EQx: SHALL assert startPressurizing while target is high and isHighPressure=0, or startDepressurizing while target is low and isHighPressure=1. It SHALL never assert both.
REQ-021 EQx: when the pressure matches the target, SHALL advance the next edge. If the pressure already matches on entry, SHALL advance after one cycle with no pump command.
REQ-022 EQx: the timer SHALL clear on entry and count each cycle. When the count reaches PUMP_TIMEOUT with the target unmet, SHALL go to FAULT.
REQ-023 OPEN1/OPEN2: SHALL assert the unlock for the entry/exit door respectively, and advance when that door's closed input goes 0.
REQ-024 ENTER/EXIT: SHALL keep the unlock asserted until that door's closed input returns to 1, then go to EQ2/DONE respectively.
REQ-025 A closed input dropping while in an EQx state SHALL go to FAULT and drop the pump commands in the same transition.
REQ-026 DONE: SHALL assert done for exactly one cycle, then return to IDLE.
REQ-027 abort=1 SHALL return to IDLE from SEAL or EQ1. abort SHALL be ignored from OPEN1 onward, so an occupant is never stranded.
REQ-028 FAULT: SHALL assert fault, deassert all pump and unlock outputs, and stay in FAULT until reset.
REQ-029 If start and abort are both 1 in IDLE, SHALL start the cycle; the abort is not retained.

Reset
REQ-030 reset=1 SHALL force IDLE, clear the timer and latched mode, and drive busy, the pump outputs, the unlock outputs, done and fault to 0 on the next edge. This SHALL hold from any state, including mid-pump and FAULT.

Structure
REQ-031 The state enumeration, the mode constants (ARRIVAL=0, DEPARTURE=1) and the default PUMP_TIMEOUT SHALL reside in shared package airlock_pkg.
REQ-032 The timer SHALL be sub-module airlock_pump_timer (ports: clear, enable, expired; parameterised by TIMER_WIDTH and PUMP_TIMEOUT).

Verification
REQ-033 Reset, then arrival with doors closed and isHighPressure=1: SHALL give SEAL->EQ1 with startDepressurizing until isHighPressure=0, then odUnlock. Outer door cycled open and closed SHALL give EQ2 with startPressurizing, then idUnlock. Inner door cycled SHALL give done=1 for one cycle, then busy=0.
REQ-034 Departure with pressure already high at EQ1: SHALL produce no pump command in EQ1 and idUnlock one cycle after EQ1 entry; the rest mirrors REQ-033.
REQ-035 With PUMP_TIMEOUT=8, hold isHighPressure=1 during arrival EQ1: SHALL give fault=1 after 8 cycles of startDepressurizing with all commands 0, and fault SHALL persist until reset.
REQ-036 abort=1 in EQ1: SHALL give IDLE next edge with busy=0. abort=1 in ENTER SHALL be ignored and the cycle SHALL complete.
REQ-037 reset=1 mid-EQ2 with startPressurizing=1: SHALL give all outputs 0 next edge. A following start SHALL begin a clean cycle.

Source files
------------

// File: rtl/airlock_pkg.sv
// Shared airlock definitions: state encoding, cycle direction constants and
// the default pump timeout.
package airlock_pkg;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_SEAL  = 4'd1,
    S_EQ1   = 4'd2,
    S_OPEN1 = 4'd3,
    S_ENTER = 4'd4,
    S_EQ2   = 4'd5,
    S_OPEN2 = 4'd6,
    S_EXIT  = 4'd7,
    S_DONE  = 4'd8,
    S_FAULT = 4'd9
  } airlock_state_e;

  localparam logic ARRIVAL   = 1'b0;
  localparam logic DEPARTURE = 1'b1;

  localparam int DEFAULT_PUMP_TIMEOUT = 8;

endpackage

// File: rtl/airlock_pump_timer.sv
// Counts clocks spent in one equalize phase; expired flags the cycle that is
// the PUMP_TIMEOUT-th of the phase, so the FSM faults on the following edge.
module airlock_pump_timer #(
  parameter int TIMER_WIDTH  = 4,
  parameter int PUMP_TIMEOUT = airlock_pkg::DEFAULT_PUMP_TIMEOUT
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TIMER_WIDTH-1:0] LAST = TIMER_WIDTH'(PUMP_TIMEOUT - 1);

  logic [TIMER_WIDTH-1:0] count_q;

  assign expired = enable && (count_q == LAST);

  // Saturates at LAST so a stalled FSM cannot wrap the count.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count_q <= '0;
    end else if (enable && (count_q != LAST)) begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/airlock_cycle_controller.sv
// Airlock cycle sequencer: seals, equalizes, and walks the occupant through
// entry and exit doors. All outputs come straight from registers.
module airlock_cycle_controller
  import airlock_pkg::*;
#(
  parameter int PUMP_TIMEOUT = DEFAULT_PUMP_TIMEOUT,
  parameter int TIMER_WIDTH  = 4
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           start,
  input  logic           mode,
  input  logic           abort,
  input  logic           odClosed,
  input  logic           idClosed,
  input  logic           isHighPressure,
  output logic           busy,
  output logic           startPressurizing,
  output logic           startDepressurizing,
  output logic           odUnlock,
  output logic           idUnlock,
  output logic           done,
  output logic           fault,
  output airlock_state_e dbg_state
);

  // Handshake: none; start is a level sampled only in IDLE, doors and
  // pressure are level status inputs sampled every rising edge.

  airlock_state_e state_q, state_d;
  logic mode_q, mode_d;
  logic busy_q, busy_d, prs_q, prs_d, dep_q, dep_d;
  logic odu_q, odu_d, idu_q, idu_d, done_q, done_d, fault_q, fault_d;

  logic in_eq, timer_expired, eq_target, pressure_ok, doors_closed;
  logic entry_closed, exit_closed, next_target;

  assign in_eq        = (state_q == S_EQ1) || (state_q == S_EQ2);
  assign eq_target    = (state_q == S_EQ1) ? mode_q : ~mode_q;
  assign pressure_ok  = (isHighPressure == eq_target);
  assign doors_closed = odClosed && idClosed;
  assign entry_closed = (mode_q == DEPARTURE) ? idClosed : odClosed;
  assign exit_closed  = (mode_q == DEPARTURE) ? odClosed : idClosed;

  airlock_pump_timer #(
    .TIMER_WIDTH (TIMER_WIDTH),
    .PUMP_TIMEOUT(PUMP_TIMEOUT)
  ) u_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (!in_eq),
    .enable (in_eq),
    .expired(timer_expired)
  );

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    case (state_q)
      S_IDLE:  if (start) begin
                 mode_d  = mode;
                 state_d = S_SEAL;
               end
      S_SEAL:  if (abort)             state_d = S_IDLE;
               else if (doors_closed) state_d = S_EQ1;
      S_EQ1, S_EQ2: begin
        // A door opening under a pressure differential outranks everything.
        if (!doors_closed)                     state_d = S_FAULT;
        else if (abort && state_q == S_EQ1)    state_d = S_IDLE;
        else if (pressure_ok)                  state_d = (state_q == S_EQ1) ? S_OPEN1 : S_OPEN2;
        else if (timer_expired)                state_d = S_FAULT;
      end
      S_OPEN1: if (!entry_closed) state_d = S_ENTER;
      S_ENTER: if (entry_closed)  state_d = S_EQ2;
      S_OPEN2: if (!exit_closed)  state_d = S_EXIT;
      S_EXIT:  if (exit_closed)   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FAULT;
    endcase

    // Outputs are computed for the state being entered, then registered.
    next_target = (state_d == S_EQ1) ? mode_d : ~mode_d;
    busy_d  = (state_d != S_IDLE);
    prs_d   = 1'b0;
    dep_d   = 1'b0;
    if (state_d == S_EQ1 || state_d == S_EQ2) begin
      prs_d = next_target && !isHighPressure;
      dep_d = !next_target && isHighPressure;
    end
    odu_d   = ((state_d == S_OPEN1 || state_d == S_ENTER) && mode_d == ARRIVAL) ||
              ((state_d == S_OPEN2 || state_d == S_EXIT)  && mode_d == DEPARTURE);
    idu_d   = ((state_d == S_OPEN1 || state_d == S_ENTER) && mode_d == DEPARTURE) ||
              ((state_d == S_OPEN2 || state_d == S_EXIT)  && mode_d == ARRIVAL);
    done_d  = (state_d == S_DONE);
    fault_d = (state_d == S_FAULT);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      mode_q  <= ARRIVAL;
      busy_q  <= 1'b0;
      prs_q   <= 1'b0;
      dep_q   <= 1'b0;
      odu_q   <= 1'b0;
      idu_q   <= 1'b0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      busy_q  <= busy_d;
      prs_q   <= prs_d;
      dep_q   <= dep_d;
      odu_q   <= odu_d;
      idu_q   <= idu_d;
      done_q  <= done_d;
      fault_q <= fault_d;
    end
  end

  assign busy                = busy_q;
  assign startPressurizing   = prs_q;
  assign startDepressurizing = dep_q;
  assign odUnlock            = odu_q;
  assign idUnlock            = idu_q;
  assign done                = done_q;
  assign fault               = fault_q;
  assign dbg_state           = state_q;

endmodule
